// File: rtl/storm_dram_arb_pkg.sv
// Shared types and constants for the STORM data-RAM arbiter.
package storm_dram_arb_pkg;

  // Default geometry of the STORM data RAM.
  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 10;
  localparam int STARVE_MAX_DEF = 8;

  // Starvation counter width; covers STARVE_MAX up to 15.
  localparam int CNT_W = 4;

  // Host-side transaction phases.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/storm_dram_arb.sv
// STORM data-RAM arbiter: CPU core has priority, PIO host gets a guaranteed
// slot once it has lost STARVE_MAX consecutive cycles to the core.
module storm_dram_arb
  import storm_dram_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iCoreReq,
  input  logic              iCoreWE,
  input  logic [ADDR_W-1:0] iCoreAddr,
  input  logic [DATA_W-1:0] iCoreData,
  output logic [DATA_W-1:0] oCoreQ,
  output logic              oCoreStall,
  input  logic              iHostReq,
  input  logic              iHostWE,
  input  logic [ADDR_W-1:0] iHostAddr,
  input  logic [DATA_W-1:0] iHostData,
  output logic              oHostAck,
  output logic [DATA_W-1:0] oHostQ,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWE,
  output logic [DATA_W-1:0] oRamData,
  input  logic [DATA_W-1:0] iRamQ
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] hq_q, hq_d;
  logic              host_grant_s;

  // Host owns the RAM in WAIT when the core is idle or the host has starved long enough.
  always_comb begin
    host_grant_s = iRst_n & (state_q == ST_WAIT) & (~iCoreReq | (cnt_q == STARVE_LIM));
  end

  // Next-state, starvation count and host read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hq_d    = hq_q;
    case (state_q)
      ST_IDLE: begin
        if (iHostReq) begin
          state_d = ST_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (host_grant_s) begin
          state_d = ST_ACK;
          cnt_d   = {CNT_W{1'b0}};
          if (!iHostWE) begin
            hq_d = iRamQ;
          end else begin
            hq_d = hq_q;
          end
        end else if (cnt_q < STARVE_LIM) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ACK: begin
        // The ack holds until the host drops its request; only then may a new access start.
        if (!iHostReq) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    ack_d = (state_d == ST_ACK);
  end

  // State and host-side registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ack_q   <= 1'b0;
      hq_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      hq_q    <= hq_d;
    end
  end

  // RAM port mux; writes are suppressed while reset is asserted.
  always_comb begin
    if (host_grant_s) begin
      oRamAddr = iHostAddr;
      oRamData = iHostData;
      oRamWE   = iHostWE;
    end else begin
      oRamAddr = iCoreAddr;
      oRamData = iCoreData;
      oRamWE   = iRst_n & iCoreWE & iCoreReq;
    end
    oCoreStall = iCoreReq & host_grant_s;
    oCoreQ     = iRamQ;
    oHostAck   = ack_q;
    oHostQ     = hq_q;
  end

endmodule

// File: tb/tb_storm_dram_arb.sv
// Self-checking bench for storm_dram_arb: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_storm_dram_arb;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int SM = 8;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iCoreReq, iCoreWE;
  logic [AW-1:0] iCoreAddr;
  logic [DW-1:0] iCoreData;
  logic [DW-1:0] oCoreQ;
  logic          oCoreStall;
  logic          iHostReq, iHostWE;
  logic [AW-1:0] iHostAddr;
  logic [DW-1:0] iHostData;
  logic          oHostAck;
  logic [DW-1:0] oHostQ;
  logic [AW-1:0] oRamAddr;
  logic          oRamWE;
  logic [DW-1:0] oRamData;
  logic [DW-1:0] iRamQ;

  int n_err = 0;
  int n_chk = 0;
  int wr40  = 0;

  storm_dram_arb #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iCoreReq(iCoreReq), .iCoreWE(iCoreWE), .iCoreAddr(iCoreAddr), .iCoreData(iCoreData),
    .oCoreQ(oCoreQ), .oCoreStall(oCoreStall),
    .iHostReq(iHostReq), .iHostWE(iHostWE), .iHostAddr(iHostAddr), .iHostData(iHostData),
    .oHostAck(oHostAck), .oHostQ(oHostQ),
    .oRamAddr(oRamAddr), .oRamWE(oRamWE), .oRamData(oRamData), .iRamQ(iRamQ)
  );

  always #5 iClk = ~iClk;

  // Behavioural single-port RAM: async read, write on clock edge.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign iRamQ = ram[oRamAddr];
  always @(posedge iClk) begin
    if (oRamWE) ram[oRamAddr] <= oRamData;
    if (oRamWE && oRamAddr == 10'h040) wr40 <= wr40 + 1;
  end

  // Reference model: expected memory image and host transaction progress.
  logic [DW-1:0] refmem [0:(1<<AW)-1];
  bit            m_wait, m_ack;
  int            m_lost;
  logic [DW-1:0] m_hq;
  bit            e_grant, e_stall, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected RAM-port behaviour for the current inputs.
  task automatic model_comb();
    e_grant = iRst_n && m_wait && (!iCoreReq || m_lost == SM);
    e_stall = iCoreReq && e_grant;
    e_addr  = e_grant ? iHostAddr : iCoreAddr;
    e_data  = e_grant ? iHostData : iCoreData;
    e_we    = iRst_n && (e_grant ? iHostWE : (iCoreWE && iCoreReq));
  endtask

  // Advance the model across one clock edge.
  task automatic model_seq();
    if (!iRst_n) begin
      m_wait = 0; m_ack = 0; m_lost = 0; m_hq = '0;
    end else begin
      if (m_wait) begin
        if (e_grant) begin
          if (!iHostWE) m_hq = refmem[iHostAddr];
          m_wait = 0;
          m_ack  = 1;
        end else begin
          m_lost = (m_lost < SM) ? m_lost + 1 : SM;
        end
      end else if (m_ack) begin
        if (!iHostReq) m_ack = 0;
      end else if (iHostReq) begin
        m_wait = 1;
        m_lost = 0;
      end
      if (e_we) refmem[e_addr] = e_data;
    end
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic cyc_pre();
    #4;
    model_comb();
    chk("ram_we", 32'(oRamWE), 32'(e_we));
    chk("core_stall", 32'(oCoreStall), 32'(e_stall));
    chk("ram_addr", 32'(oRamAddr), 32'(e_addr));
    if (e_we) chk("ram_data", 32'(oRamData), 32'(e_data));
    chk("core_q", 32'(oCoreQ), 32'(refmem[e_addr]));
    chk("host_ack", 32'(oHostAck), 32'(m_ack));
    chk("host_q", 32'(oHostQ), 32'(m_hq));
  endtask

  task automatic tick();
    @(posedge iClk);
    model_seq();
    #1;
  endtask

  task automatic full_cyc();
    cyc_pre();
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i] = '0;
      refmem[i] = '0;
    end
    m_wait = 0; m_ack = 0; m_lost = 0; m_hq = '0;

    // 1: reset with both sides requesting.
    iRst_n = 1'b0; iCoreReq = 1'b1; iCoreWE = 1'b1; iCoreAddr = 10'h001; iCoreData = 16'h0F0F;
    iHostReq = 1'b1; iHostWE = 1'b1; iHostAddr = 10'h002; iHostData = 16'hF0F0;
    @(posedge iClk); #1;
    for (int i = 0; i < 3; i++) begin
      cyc_pre();
      chk("rst_we", 32'(oRamWE), 32'd0);
      chk("rst_ack", 32'(oHostAck), 32'd0);
      chk("rst_hq", 32'(oHostQ), 32'd0);
      tick();
    end

    // 2: uncontested host write then read-back.
    iRst_n = 1'b1; iCoreReq = 1'b0; iCoreWE = 1'b0;
    iHostReq = 1'b1; iHostWE = 1'b1; iHostAddr = 10'h155; iHostData = 16'hBEEF;
    full_cyc();
    cyc_pre();
    chk("hw_addr", 32'(oRamAddr), 32'h155);
    chk("hw_we", 32'(oRamWE), 32'd1);
    chk("hw_data", 32'(oRamData), 32'hBEEF);
    tick();
    for (int i = 0; i < 2; i++) begin
      cyc_pre();
      chk("hw_ack", 32'(oHostAck), 32'd1);
      tick();
    end
    iHostReq = 1'b0;
    full_cyc();
    cyc_pre();
    chk("hw_ack_clr", 32'(oHostAck), 32'd0);
    tick();
    iHostReq = 1'b1; iHostWE = 1'b0;
    full_cyc();
    full_cyc();
    cyc_pre();
    chk("hr_ack", 32'(oHostAck), 32'd1);
    chk("hr_q", 32'(oHostQ), 32'hBEEF);
    tick();
    iHostReq = 1'b0;
    full_cyc();
    full_cyc();

    // 3: core writes every cycle; host is granted on its 9th WAIT cycle.
    iHostReq = 1'b1; iHostWE = 1'b1; iHostAddr = 10'h020; iHostData = 16'hAAAA;
    iCoreReq = 1'b1; iCoreWE = 1'b1; iCoreAddr = 10'h030; iCoreData = 16'h5000;
    full_cyc();
    for (int k = 1; k <= 9; k++) begin
      iCoreAddr = 10'(10'h030 + k); iCoreData = 16'(16'h5000 + k);
      cyc_pre();
      chk("starve_stall", 32'(oCoreStall), (k == 9) ? 32'd1 : 32'd0);
      if (k == 9) chk("starve_addr", 32'(oRamAddr), 32'h020);
      tick();
    end
    cyc_pre();
    chk("retry_stall", 32'(oCoreStall), 32'd0);
    chk("retry_addr", 32'(oRamAddr), 32'h039);
    tick();
    chk("ram_host", 32'(ram[10'h020]), 32'hAAAA);
    chk("ram_core", 32'(ram[10'h039]), 32'h5009);
    iHostReq = 1'b0; iCoreReq = 1'b0; iCoreWE = 1'b0;
    full_cyc();
    full_cyc();

    // 4: core write then same-cycle core read of the top address.
    iCoreReq = 1'b1; iCoreWE = 1'b1; iCoreAddr = 10'h3FF; iCoreData = 16'h1234;
    full_cyc();
    iCoreWE = 1'b0;
    cyc_pre();
    chk("cr_q", 32'(oCoreQ), 32'h1234);
    chk("cr_stall", 32'(oCoreStall), 32'd0);
    chk("cr_we", 32'(oRamWE), 32'd0);
    tick();

    // 5: reset while a host write waits behind the core.
    iCoreAddr = 10'h100;
    iHostReq = 1'b1; iHostWE = 1'b1; iHostAddr = 10'h010; iHostData = 16'h7777;
    full_cyc();
    full_cyc();
    iRst_n = 1'b0; iHostReq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc_pre();
      chk("mid_rst_we", 32'(oRamWE), 32'd0);
      tick();
    end
    iRst_n = 1'b1; iCoreReq = 1'b0;
    cyc_pre();
    chk("mid_rst_ack", 32'(oHostAck), 32'd0);
    tick();
    chk("mid_rst_ram", 32'(ram[10'h010]), 32'h0000);

    // 6: request held after ack, then a second access after passing through IDLE.
    iHostReq = 1'b1; iHostWE = 1'b1; iHostAddr = 10'h040; iHostData = 16'h1111;
    full_cyc();
    full_cyc();
    for (int i = 0; i < 5; i++) begin
      cyc_pre();
      chk("hold_ack", 32'(oHostAck), 32'd1);
      tick();
    end
    chk("hold_one_wr", 32'(wr40), 32'd1);
    iHostReq = 1'b0;
    full_cyc();
    iHostReq = 1'b1; iHostData = 16'h2222;
    cyc_pre();
    chk("rearm_idle_ack", 32'(oHostAck), 32'd0);
    tick();
    cyc_pre();
    chk("rearm_wait_ack", 32'(oHostAck), 32'd0);
    tick();
    cyc_pre();
    chk("rearm_ack", 32'(oHostAck), 32'd1);
    tick();
    chk("rearm_two_wr", 32'(wr40), 32'd2);
    chk("rearm_ram", 32'(ram[10'h040]), 32'h2222);
    iHostReq = 1'b0;
    full_cyc();
    full_cyc();

    // Randomized run: random core traffic, 4-phase host, occasional resets.
    for (int n = 0; n < 3000; n++) begin
      iRst_n    = ($urandom_range(0, 199) != 0);
      iCoreReq  = ($urandom_range(0, 3) != 0);
      iCoreWE   = $urandom_range(0, 1) == 1;
      iCoreAddr = 10'(10'h200 + $urandom_range(0, 15));
      iCoreData = 16'($urandom);
      if (!iHostReq && !m_ack && !m_wait) begin
        if ($urandom_range(0, 3) == 0) begin
          iHostReq  = 1'b1;
          iHostWE   = $urandom_range(0, 1) == 1;
          iHostAddr = 10'(10'h200 + $urandom_range(0, 15));
          iHostData = 16'($urandom);
        end
      end else if (iHostReq && m_ack) begin
        if ($urandom_range(0, 2) == 0) iHostReq = 1'b0;
      end else if (iHostReq && m_wait) begin
        if ($urandom_range(0, 63) == 0) iHostReq = 1'b0;
      end
      full_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
